// File: rtl/mult_div_unit_if.sv
// Operand, control and HI/LO result bundle shared by the E-stage decoder and the multiply/divide unit.
interface mult_div_unit_if;
  logic        Start;
  logic [1:0]  MDOp;
  logic [1:0]  HiLoWe;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] Hi;
  logic [31:0] Lo;

  // Start is a single-cycle request taken only on an edge where Busy=0; Busy is
  // the only back-pressure, and Hi/Lo are valid whenever Busy=0.
  modport master (output Start, MDOp, HiLoWe, A, B, input Busy, Hi, Lo);
  modport slave  (input Start, MDOp, HiLoWe, A, B, output Busy, Hi, Lo);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS-style HI/LO multiply/divide unit: operands are latched on Start, the
// result is computed on the latched values and lands in HI/LO when the down-counter expires.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   bus,
  output logic             dbg_state
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;

  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;

  // op_q[0] selects the unsigned variant for both multiply and divide.
  always_comb begin
    a_ext = op_q[0] ? {32'b0, a_q} : {{32{a_q[31]}}, a_q};
    b_ext = op_q[0] ? {32'b0, b_q} : {{32{b_q[31]}}, b_q};
    prod  = a_ext * b_ext;
  end

  // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    a_neg = ~op_q[0] & a_q[31];
    b_neg = ~op_q[0] & b_q[31];
    a_mag = a_neg ? -a_q : a_q;
    b_mag = b_neg ? -b_q : b_q;
    b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag = a_mag / b_div;
    r_mag = a_mag % b_div;
    quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d = RUN;
          a_d     = bus.A;
          b_d     = bus.B;
          op_d    = bus.MDOp;
          cnt_d   = bus.MDOp[1] ? DIV_LOAD : MULT_LOAD;
        end else begin
          if (bus.HiLoWe[1]) hi_d = bus.A;
          if (bus.HiLoWe[0]) lo_d = bus.A;
        end
      end
      RUN: begin
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (!op_q[1]) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.Busy  = (state_q == RUN);
  assign bus.Hi    = hi_q;
  assign bus.Lo    = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, Busy lengths, ignored requests and reset.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic reset;
  logic dbg_state;
  int   n_cmp = 0;
  int   n_err = 0;

  mult_div_unit_if bus();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.Start  = 1'b0;
    bus.MDOp   = 2'b00;
    bus.HiLoWe = 2'b00;
    bus.A      = '0;
    bus.B      = '0;
  endtask

  // Call #1 after an edge; leaves time #1 after the edge on which Busy was seen low.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cycles,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] hi0, lo0;
    int n;
    bit held;
    hi0 = bus.Hi;
    lo0 = bus.Lo;
    bus.Start = 1'b1; bus.MDOp = op; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    idle_inputs();
    n = 0;
    held = 1'b1;
    while (bus.Busy && n < 200) begin
      n++;
      if (bus.Hi !== hi0 || bus.Lo !== lo0) held = 1'b0;
      @(posedge clk); #1;
    end
    check_eq({tag, " busy_cycles"}, 64'(n), 64'(exp_cycles));
    check_eq({tag, " hold"}, 64'(held), 64'd1);
    check_eq({tag, " hi"}, 64'(bus.Hi), 64'(exp_hi));
    check_eq({tag, " lo"}, 64'(bus.Lo), 64'(exp_lo));
  endtask

  task automatic write_hilo(input logic [1:0] we, input logic [31:0] a);
    bus.HiLoWe = we; bus.A = a;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    int n;
    int extra;
    idle_inputs();
    reset = 1'b1;
    #1;
    check_eq("reset busy", 64'(bus.Busy), 64'd0);
    check_eq("reset hi", 64'(bus.Hi), 64'd0);
    check_eq("reset lo", 64'(bus.Lo), 64'd0);
    check_eq("reset state", 64'(dbg_state), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_op("mult", 2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div negdivisor", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_op("divu", 2'b11, 32'hFFFF_FFF9, 32'h0000_0010, 10, 32'h0000_0009, 32'h0FFF_FFFF);

    write_hilo(2'b10, 32'h0000_1234);
    write_hilo(2'b01, 32'h0000_5678);
    check_eq("mthi", 64'(bus.Hi), 64'h1234);
    check_eq("mtlo", 64'(bus.Lo), 64'h5678);
    run_op("divu by zero", 2'b11, 32'h0000_0064, 32'h0000_0000, 10, 32'h0000_1234, 32'h0000_5678);
    write_hilo(2'b11, 32'hA5A5_5A5A);
    check_eq("mthi+mtlo hi", 64'(bus.Hi), 64'hA5A5_5A5A);
    check_eq("mthi+mtlo lo", 64'(bus.Lo), 64'hA5A5_5A5A);

    // Start wins over HiLoWe on the same edge: Lo must end as the product, never the A value.
    bus.HiLoWe = 2'b01;
    run_op("start priority", 2'b01, 32'h0000_0006, 32'h0000_0007, 5, 32'h0, 32'h0000_002A);

    // Requests raised mid-multiply must be dropped entirely.
    bus.Start = 1'b1; bus.MDOp = 2'b00; bus.A = 32'h0001_0000; bus.B = 32'h0001_0000;
    @(posedge clk); #1;
    idle_inputs();
    n = 0;
    while (bus.Busy && n < 200) begin
      n++;
      if (n == 2) begin
        bus.Start = 1'b1; bus.MDOp = 2'b10; bus.HiLoWe = 2'b01;
        bus.A = 32'hDEAD_BEEF; bus.B = 32'h0000_0001;
      end else if (n == 3) begin
        idle_inputs();
      end
      @(posedge clk); #1;
    end
    check_eq("ignored busy_cycles", 64'(n), 64'd5);
    check_eq("ignored hi", 64'(bus.Hi), 64'h0000_0001);
    check_eq("ignored lo", 64'(bus.Lo), 64'h0000_0000);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.Busy) extra++;
      @(posedge clk); #1;
    end
    check_eq("ignored no second busy", 64'(extra), 64'd0);

    // Back to back: the second Start is driven in the single cycle Busy is low.
    run_op("b2b mult", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'h0000_0000, 32'h0000_0001);
    check_eq("b2b gap busy low", 64'(bus.Busy), 64'd0);
    run_op("b2b div", 2'b10, 32'h0000_0064, 32'hFFFF_FFF9, 10, 32'h0000_0002, 32'hFFFF_FFF2);

    // Reset in the third Busy cycle of a divide.
    bus.Start = 1'b1; bus.MDOp = 2'b10; bus.A = 32'h0000_0064; bus.B = 32'h0000_0007;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("pre-reset busy", 64'(bus.Busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async reset busy", 64'(bus.Busy), 64'd0);
    check_eq("async reset hi", 64'(bus.Hi), 64'd0);
    check_eq("async reset lo", 64'(bus.Lo), 64'd0);
    bus.Start = 1'b1; bus.MDOp = 2'b00; bus.HiLoWe = 2'b11; bus.A = 32'h0000_FFFF; bus.B = 32'h2;
    @(posedge clk); #1;
    check_eq("reset ignores start", 64'(bus.Busy), 64'd0);
    check_eq("reset ignores hilowe", 64'(bus.Lo), 64'd0);
    idle_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
    run_op("post-reset mult", 2'b00, 32'h0000_0003, 32'h0000_0004, 5, 32'h0000_0000, 32'h0000_000C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
